fetch_align_queue: RTL and testbench
====================================

// Module: fetch_align_queue
// PURPOSE
//  Parametrised fetch front-end for the RV32IC pipeline: issues word reads to the I-cache and buffers returned halfwords.
//  Realigns 16-bit compressed and 32-bit (possibly word-straddling) instructions into one instruction per handshake for IF/ID.
//  Replaces fixed PC+4 fetch; accepts a redirect (branch/jal/jalr target, any halfword address) from EX.
// PARAMETERS
//  XLEN         32  PC/address width
//  DEPTH        4   queue capacity in halfwords; power of 2, >= 4
//  ENDIAN_SWAP  1   1: byte-reverse icache_rdata before use (cache is big-endian-ordered); 0: use as-is
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous active-high reset
//  icache_ren     out  1        read request
//  icache_addr    out  XLEN-2   word address (fetch_pc[XLEN-1:2])
//  icache_stall   in   1        1: data not ready, hold request
//  icache_rdata   in   32       read data, valid in cycle where icache_ren=1 and icache_stall=0
//  redirect_i     in   1        flush queue, restart fetch at redirect_pc_i
//  redirect_pc_i  in   XLEN     target; bit0 ignored
//  instr_valid_o  out  1        instr_o/instr_pc_o/instr_is_c_o valid
//  instr_ready_i  in   1        decode accepts instruction
//  instr_o        out  32       instruction; compressed = {16'h0, halfword}
//  instr_pc_o     out  XLEN     PC of instr_o
//  instr_is_c_o   out  1        1: 16-bit instruction (next PC = +2)
//  count_o        out  clog2(DEPTH+1)  halfwords held
// BEHAVIOUR
//  Reset (rst=1 at clk edge): queue empty, count_o=0, fetch_pc=0, skip_lo=0; while rst=1 icache_ren=0, instr_valid_o=0.
//  Queue: circular buffer of DEPTH {halfword, pc} entries, rd/wr pointers wrap modulo DEPTH.
//  Request: icache_ren = !rst & !redirect_i & (count_o <= DEPTH-2); icache_addr = fetch_pc word.
//  Accept: ren & !stall -> push low halfword (pc=fetch_pc) then high (pc=fetch_pc+2); if skip_lo, push only high, clear skip_lo.
//   fetch_pc += 4 on accept; icache_addr held stable while icache_stall=1.
//  Head decode: h0 = head entry. h0[1:0]==2'b11 -> 32-bit: valid needs count>=2, instr_o={h1,h0}, is_c=0.
//   else 16-bit: valid needs count>=1, instr_o={16'h0,h0}, is_c=1. instr_pc_o = head pc. Outputs combinational from queue state.
//  Pop: instr_valid_o & instr_ready_i -> rd pointer += 1 (16-bit) or 2 (32-bit).
//  Simultaneous push and pop: count_next = count + pushed - popped; request gating uses pre-pop count (never overflows).
//  Redirect (priority over everything): queue cleared, fetch_pc = {redirect_pc_i[XLEN-1:2],2'b00}, skip_lo = redirect_pc_i[1];
//   same-cycle cache data discarded; instr_valid_o forced 0 and no pop. A pending stalled request is abandoned.
//  Latency: redirect at t -> ren with new addr at t+1; if no stall, instr_valid_o at t+2 (32-bit at odd halfword: t+3).
//  Straddling 32-bit instr (low half at word end) held until next word pushed; never emitted partially.
//  Reset mid-operation: same as reset; in-flight cache response ignored.
//  instr_o/instr_pc_o don't-care when instr_valid_o=0; must not glitch X when valid.
// TESTING
//  1 Reset, rdata(word 0)=0x13000000 (swapped 0x00000013), ready=1 -> cycle 2: valid, instr 0x00000013, pc 0x0, is_c 0; next pc 0x4.
//  2 Word 0 halves lo 0x4501, hi 0x0001 -> two outputs: 0x00004501 pc 0x0 is_c 1, then 0x00000001 pc 0x2 is_c 1.
//  3 Word0 = lo 0x0001, hi 0x0513; word1 lo 0x00A0 -> 0x00000001 pc 0x0, then 0x00A00513 pc 0x2 only after word1 accepted.
//  4 redirect_pc_i=0x106 -> next cycle icache_addr=0x41; low half dropped; first output pc 0x106; no stale pre-redirect output.
//  5 ready=0, DEPTH=4 -> count reaches 4, ren low when count>2, no halfword lost; ready=1 resumes in order, PCs contiguous.
//  6 icache_stall=1 for 3 cycles at addr 0x2, redirect to 0x20 in cycle 2 -> addr becomes 0x8, stale data dropped, first pc 0x20.

Source files
------------

// File: rtl/fetch_align_queue.sv
// RV32IC fetch front-end: word reads from the I-cache feed a halfword queue.
// The head of the queue is realigned into one 16- or 32-bit instruction per handshake.
module fetch_align_queue #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 4,
   parameter int ENDIAN_SWAP = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       icache_ren,
   output logic [XLEN-3:0]            icache_addr,
   input  logic                       icache_stall,
   input  logic [31:0]                icache_rdata,
   input  logic                       redirect_i,
   input  logic [XLEN-1:0]            redirect_pc_i,
   output logic                       instr_valid_o,
   input  logic                       instr_ready_i,
   output logic [31:0]                instr_o,
   output logic [XLEN-1:0]            instr_pc_o,
   output logic                       instr_is_c_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [XLEN-1:0] PC_STEP_HALF = XLEN'(2);
   localparam logic [XLEN-1:0] PC_STEP_WORD = XLEN'(4);

   function automatic logic [31:0] byte_swap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   logic [15:0]     hw_q [DEPTH];
   logic [XLEN-1:0] pc_q [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] fetch_pc;
   logic            skip_lo;

   logic [31:0]     rdata;
   logic            accept;
   logic            pop;
   logic            head_is32;
   logic [15:0]     h0;
   logic [15:0]     h1;
   logic [1:0]      push_n;
   logic [1:0]      pop_n;
   logic            unused_bit0;

   // Redirect targets are halfword-aligned, so bit 0 carries no information.
   assign unused_bit0 = redirect_pc_i[0];

   // Cache data byte order normalisation.
   always_comb begin
      if (ENDIAN_SWAP != 0) begin
         rdata = byte_swap(icache_rdata);
      end else begin
         rdata = icache_rdata;
      end
   end

   // Fetch request and head-of-queue decode.
   always_comb begin
      icache_ren   = !rst && !redirect_i && (count <= CW'(DEPTH-2));
      icache_addr  = fetch_pc[XLEN-1:2];
      accept       = icache_ren && !icache_stall;
      h0           = hw_q[rd_ptr];
      h1           = hw_q[rd_ptr + PW'(1)];
      head_is32    = (h0[1:0] == 2'b11);
      instr_pc_o   = pc_q[rd_ptr];
      instr_is_c_o = !head_is32;
      count_o      = count;
      if (head_is32) begin
         instr_o       = {h1, h0};
         instr_valid_o = !rst && !redirect_i && (count >= CW'(2));
      end else begin
         instr_o       = {16'h0000, h0};
         instr_valid_o = !rst && !redirect_i && (count >= CW'(1));
      end
      pop = instr_valid_o && instr_ready_i;
      if (accept) begin
         push_n = skip_lo ? 2'd1 : 2'd2;
      end else begin
         push_n = 2'd0;
      end
      if (pop) begin
         pop_n = head_is32 ? 2'd2 : 2'd1;
      end else begin
         pop_n = 2'd0;
      end
   end

   // Queue, pointers and fetch PC; redirect overrides any same-cycle push or pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fetch_pc <= '0;
         skip_lo  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            hw_q[i] <= 16'h0000;
            pc_q[i] <= '0;
         end
      end else if (redirect_i) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
         skip_lo  <= redirect_pc_i[1];
      end else begin
         if (accept) begin
            if (skip_lo) begin
               hw_q[wr_ptr] <= rdata[31:16];
               pc_q[wr_ptr] <= fetch_pc + PC_STEP_HALF;
            end else begin
               hw_q[wr_ptr]            <= rdata[15:0];
               pc_q[wr_ptr]            <= fetch_pc;
               hw_q[wr_ptr + PW'(1)]   <= rdata[31:16];
               pc_q[wr_ptr + PW'(1)]   <= fetch_pc + PC_STEP_HALF;
            end
            fetch_pc <= fetch_pc + PC_STEP_WORD;
            skip_lo  <= 1'b0;
         end else begin
            fetch_pc <= fetch_pc;
            skip_lo  <= skip_lo;
         end
         wr_ptr <= wr_ptr + PW'(push_n);
         rd_ptr <= rd_ptr + PW'(pop_n);
         count  <= count + CW'(push_n) - CW'(pop_n);
      end
   end

endmodule

// File: tb/tb_fetch_align_queue.sv
// Directed bench for fetch_align_queue with a big-endian-ordered I-cache model
// that answers combinationally from a small word memory.
module tb_fetch_align_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        icache_ren;
   logic [29:0] icache_addr;
   logic        icache_stall;
   logic [31:0] icache_rdata;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_is_c_o;
   logic [2:0]  count_o;

   logic [31:0] mem [256];
   int vectors    = 0;
   int miscompares = 0;

   fetch_align_queue #(.XLEN(32), .DEPTH(4), .ENDIAN_SWAP(1)) dut (
      .clk(clk), .rst(rst),
      .icache_ren(icache_ren), .icache_addr(icache_addr),
      .icache_stall(icache_stall), .icache_rdata(icache_rdata),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
      .instr_o(instr_o), .instr_pc_o(instr_pc_o),
      .instr_is_c_o(instr_is_c_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // The cache stores words byte-reversed relative to instruction order.
   always_comb icache_rdata = bswap(mem[icache_addr[7:0]]);

   task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic expect_instr(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                               input logic is_c, input int max_wait);
      int waited = 0;
      while (!instr_valid_o && waited < max_wait) begin
         step();
         waited++;
      end
      check_vec({tag, "_valid"}, 64'(instr_valid_o), 64'd1);
      if (instr_valid_o) begin
         check_vec({tag, "_instr"}, 64'(instr_o), 64'(ins));
         check_vec({tag, "_pc"}, 64'(instr_pc_o), 64'(pc));
         check_vec({tag, "_is_c"}, 64'(instr_is_c_o), 64'(is_c));
      end
      step();
   endtask

   task automatic do_redirect(input string tag, input logic [31:0] target);
      redirect_i    = 1'b1;
      redirect_pc_i = target;
      #1;
      check_vec({tag, "_redir_valid"}, 64'(instr_valid_o), 64'd0);
      check_vec({tag, "_redir_ren"}, 64'(icache_ren), 64'd0);
      step();
      redirect_i = 1'b0;
      #1;
      check_vec({tag, "_addr"}, 64'(icache_addr), 64'(target >> 2));
      check_vec({tag, "_ren"}, 64'(icache_ren), 64'd1);
      check_vec({tag, "_count"}, 64'(count_o), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      icache_stall  = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      instr_ready_i = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0001_0001;
      mem[0]  = 32'h0000_0013;
      mem[1]  = 32'h0000_0093;
      mem[2]  = 32'h0000_0113;
      mem[8]  = 32'h4599_4595;
      mem[16] = 32'h0001_4501;
      mem[32] = 32'h0513_0001;
      mem[33] = 32'h0001_00A0;
      mem[48] = 32'h4509_4505;
      mem[49] = 32'h4511_450D;
      mem[50] = 32'h4519_4515;
      mem[65] = 32'h4585_1111;

      // Reset
      step();
      step();
      check_vec("rst_valid", 64'(instr_valid_o), 64'd0);
      check_vec("rst_ren", 64'(icache_ren), 64'd0);
      check_vec("rst_count", 64'(count_o), 64'd0);
      rst = 1'b0;
      #1;
      check_vec("t1_ren", 64'(icache_ren), 64'd1);
      check_vec("t1_addr", 64'(icache_addr), 64'd0);

      // Test 1: 32-bit instruction from word 0 one cycle after the first request
      step();
      expect_instr("t1_first", 32'h0000_0013, 32'h0, 1'b0, 0);
      expect_instr("t1_second", 32'h0000_0093, 32'h4, 1'b0, 2);

      // Test 2: two compressed instructions in one word
      do_redirect("t2", 32'h40);
      expect_instr("t2_lo", 32'h0000_4501, 32'h40, 1'b1, 3);
      expect_instr("t2_hi", 32'h0000_0001, 32'h42, 1'b1, 3);

      // Test 3: straddling 32-bit instruction held until the next word arrives
      do_redirect("t3", 32'h80);
      step();
      icache_stall = 1'b1;
      #1;
      expect_instr("t3_c", 32'h0000_0001, 32'h80, 1'b1, 0);
      check_vec("t3_hold_valid", 64'(instr_valid_o), 64'd0);
      check_vec("t3_hold_count", 64'(count_o), 64'd1);
      check_vec("t3_hold_addr", 64'(icache_addr), 64'h21);
      step();
      check_vec("t3_hold_valid2", 64'(instr_valid_o), 64'd0);
      icache_stall = 1'b0;
      #1;
      expect_instr("t3_straddle", 32'h00A0_0513, 32'h82, 1'b0, 2);

      // Test 4: redirect to an odd halfword drops the low half
      do_redirect("t4", 32'h106);
      expect_instr("t4_first", 32'h0000_4585, 32'h106, 1'b1, 3);
      expect_instr("t4_next", 32'h0000_0001, 32'h108, 1'b1, 3);

      // Test 5: decode back-pressure fills the queue, no halfword lost
      instr_ready_i = 1'b0;
      do_redirect("t5", 32'hC0);
      step();
      step();
      check_vec("t5_full_count", 64'(count_o), 64'd4);
      check_vec("t5_full_ren", 64'(icache_ren), 64'd0);
      step();
      check_vec("t5_hold_count", 64'(count_o), 64'd4);
      instr_ready_i = 1'b1;
      #1;
      expect_instr("t5_i0", 32'h0000_4505, 32'hC0, 1'b1, 0);
      expect_instr("t5_i1", 32'h0000_4509, 32'hC2, 1'b1, 3);
      expect_instr("t5_i2", 32'h0000_450D, 32'hC4, 1'b1, 3);
      expect_instr("t5_i3", 32'h0000_4511, 32'hC6, 1'b1, 3);
      expect_instr("t5_i4", 32'h0000_4515, 32'hC8, 1'b1, 3);
      expect_instr("t5_i5", 32'h0000_4519, 32'hCA, 1'b1, 3);

      // Test 6: redirect abandons a stalled request
      icache_stall = 1'b1;
      do_redirect("t6a", 32'h8);
      step();
      check_vec("t6_stall_count", 64'(count_o), 64'd0);
      check_vec("t6_stall_addr", 64'(icache_addr), 64'h2);
      step();
      do_redirect("t6b", 32'h20);
      icache_stall = 1'b0;
      #1;
      expect_instr("t6_first", 32'h0000_4595, 32'h20, 1'b1, 3);
      expect_instr("t6_second", 32'h0000_4599, 32'h22, 1'b1, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
